// File: rtl/load_store_unit.sv
// RV32I load/store sequencer between a core request/response port and a word RAM (1 read, 1 byte-strobed write).
// Optional macro LSU_MISALIGN_CHECK_EN: when defined, misaligned accesses fault; otherwise they are force-aligned.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic [29:0] ram_r_addr,
  input  logic [31:0] ram_r_val,
  output logic        ram_w_enable,
  output logic [29:0] ram_w_addr,
  output logic [31:0] ram_w_val,
  output logic [3:0]  ram_byte_en
);

  localparam int unsigned DW  = 32;
  localparam int unsigned WAW = 30;
  localparam int unsigned BEW = 4;

  typedef enum logic [2:0] {IDLE, STORE, LD_ADDR, LD_DATA, RESP} state_e;

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [DW-1:0]    resp_rdata_q, resp_rdata_d;
  logic             mis_q, mis_d;
  logic             ill_q, ill_d;
  logic [WAW-1:0]   word_q, word_d;
  logic [DW-1:0]    wval_q, wval_d;
  logic             w_en_q, w_en_d;
  logic [BEW-1:0]   be_q, be_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;

  logic             accept_c, ill_c, mis_c, fault_c;
  logic [1:0]       off_c;
  logic [BEW-1:0]   be_c;
  logic [DW-1:0]    wval_c, lane_c, ld_c;

  // Request decode: legality, alignment, effective lane offset, store lanes
  always_comb begin
    accept_c = req_valid && (state_q == IDLE);
    if (req_we) ill_c = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else        ill_c = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
`ifdef LSU_MISALIGN_CHECK_EN
    mis_c = !ill_c && (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
    mis_c = 1'b0;
`endif
    fault_c = ill_c || mis_c;
    case (req_funct3[1:0])
      2'b00: begin
        off_c  = req_addr[1:0];
        be_c   = 4'b0001 << off_c;
        wval_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        off_c  = {req_addr[1], 1'b0};
        be_c   = 4'b0011 << off_c;
        wval_c = {2{req_wdata[15:0]}};
      end
      default: begin
        off_c  = 2'b00;
        be_c   = 4'b1111;
        wval_c = req_wdata;
      end
    endcase
  end

  // Load lane select and extension
  always_comb begin
    lane_c = ram_r_val >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   ld_c = f3_q[2] ? {24'b0, lane_c[7:0]}  : {{24{lane_c[7]}}, lane_c[7:0]};
      2'b01:   ld_c = f3_q[2] ? {16'b0, lane_c[15:0]} : {{16{lane_c[15]}}, lane_c[15:0]};
      default: ld_c = lane_c;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = fault_c ? RESP : (req_we ? STORE : LD_ADDR);
      STORE:   state_d = RESP;
      LD_ADDR: state_d = LD_DATA;
      LD_DATA: state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-register logic; outputs are registered against the upcoming state
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    w_en_d       = (state_d == STORE);
    be_d         = (state_d == STORE) ? be_c : '0;
    resp_rdata_d = resp_rdata_q;
    mis_d        = mis_q;
    ill_d        = ill_q;
    word_d       = word_q;
    wval_d       = wval_q;
    off_d        = off_q;
    f3_d         = f3_q;
    if (accept_c) begin
      resp_rdata_d = '0;
      mis_d        = mis_c;
      ill_d        = ill_c;
      word_d       = req_addr[31:2];
      wval_d       = wval_c;
      off_d        = off_c;
      f3_d         = req_funct3;
    end
    if (state_q == LD_DATA) resp_rdata_d = ld_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mis_q        <= 1'b0;
      ill_q        <= 1'b0;
      word_q       <= '0;
      wval_q       <= '0;
      w_en_q       <= 1'b0;
      be_q         <= '0;
      off_q        <= '0;
      f3_q         <= '0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mis_q        <= mis_d;
      ill_q        <= ill_d;
      word_q       <= word_d;
      wval_q       <= wval_d;
      w_en_q       <= w_en_d;
      be_q         <= be_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = mis_q;
  assign resp_illegal    = ill_q;
  assign ram_r_addr      = word_q;
  assign ram_w_addr      = word_q;
  assign ram_w_val       = wval_q;
  assign ram_w_enable    = w_en_q;
  assign ram_byte_en     = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses checked against a byte-array reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic [29:0] ram_r_addr;
  logic [31:0] ram_r_val;
  logic        ram_w_enable;
  logic [29:0] ram_w_addr;
  logic [31:0] ram_w_val;
  logic [3:0]  ram_byte_en;

  int n_tests = 0;
  int n_fail  = 0;

  logic        ram_clr;
  logic [31:0] ram [0:255];
  logic [7:0]  ref_mem [0:1023];

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .ram_r_addr(ram_r_addr), .ram_r_val(ram_r_val),
    .ram_w_enable(ram_w_enable), .ram_w_addr(ram_w_addr),
    .ram_w_val(ram_w_val), .ram_byte_en(ram_byte_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM: registered read, writes driven by byte strobes only
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram_r_val <= 32'h0;
    end else begin
      ram_r_val <= ram[ram_r_addr[7:0]];
      for (int i = 0; i < 4; i++)
        if (ram_byte_en[i]) ram[ram_w_addr[7:0]][8*i +: 8] <= ram_w_val[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full access: model the expected outcome, drive it, observe every cycle, consume the response
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input string tag);
    int a, nb, ea, cyc, we_cyc, be_cyc, exp_lat, lat;
    logic legal, mis, fault;
    logic [31:0] exp_rd, exp_wval, st_wval, st_waddr, snap_rd;
    logic [3:0]  exp_be, st_be, snap_fl;
    a  = int'(addr[9:0]);
    nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_CHECK_EN
    mis = legal && ((a % nb) != 0);
`else
    mis = 1'b0;
`endif
    fault   = !legal || mis;
    ea      = (a / nb) * nb;
    exp_lat = fault ? 1 : (we ? 2 : 3);
    exp_rd  = 32'h0;
    exp_be  = 4'h0;
    exp_wval = 32'h0;
    if (!fault && we) begin
      for (int k = 0; k < nb; k++) begin
        exp_be[(ea % 4) + k] = 1'b1;
        ref_mem[ea + k] = wdata[8*k +: 8];
      end
      for (int j = 0; j < 4; j++) exp_wval[8*j +: 8] = wdata[8*(j % nb) +: 8];
    end
    if (!fault && !we) begin
      for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = ref_mem[ea + k];
      if (!f3[2] && nb < 4 && exp_rd[8*nb-1])
        for (int k = nb; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
    end

    check($sformatf("%s/req_ready_pre", tag), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; we_cyc = 0; be_cyc = 0;
    st_be = 4'h0; st_wval = 32'h0; st_waddr = 32'h0;
    while (!resp_valid && cyc < 10) begin
      if (ram_w_enable) begin
        we_cyc++;
        st_be = ram_byte_en; st_wval = ram_w_val; st_waddr = 32'(ram_w_addr);
      end
      if (ram_byte_en != 4'h0) be_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    lat = resp_valid ? cyc : -1;
    check($sformatf("%s/latency", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s/rdata", tag), resp_rdata, exp_rd);
    check($sformatf("%s/misaligned", tag), 32'(resp_misaligned), 32'(mis));
    check($sformatf("%s/illegal", tag), 32'(resp_illegal), 32'(!legal));
    check($sformatf("%s/write_cycles", tag), 32'(we_cyc), (!fault && we) ? 32'd1 : 32'd0);
    check($sformatf("%s/strobe_cycles", tag), 32'(be_cyc), (!fault && we) ? 32'd1 : 32'd0);
    check($sformatf("%s/ram_quiet_in_resp", tag), 32'({ram_w_enable, ram_byte_en}), 32'd0);
    if (!fault && we) begin
      check($sformatf("%s/byte_en", tag), 32'(st_be), 32'(exp_be));
      check($sformatf("%s/w_val", tag), st_wval, exp_wval);
      check($sformatf("%s/w_addr", tag), st_waddr, 32'(addr >> 2));
    end
    snap_rd = resp_rdata;
    snap_fl = {resp_valid, req_ready, resp_misaligned, resp_illegal};
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check($sformatf("%s/hold_flags", tag), 32'({resp_valid, req_ready, resp_misaligned, resp_illegal}),
            32'({1'b1, 1'b0, snap_fl[1:0]}));
      check($sformatf("%s/hold_rdata", tag), resp_rdata, snap_rd);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check($sformatf("%s/post_consume", tag), 32'({req_ready, resp_valid}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [2:0]  legal_ld [0:4];
    logic [31:0] r_addr;
    legal_ld[0] = 3'd0; legal_ld[1] = 3'd1; legal_ld[2] = 3'd2;
    legal_ld[3] = 3'd4; legal_ld[4] = 3'd5;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; ram_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/handshake", 32'({req_ready, resp_valid, resp_misaligned, resp_illegal}), 32'b1000);
    check("reset/rdata", resp_rdata, 32'h0);
    check("reset/ram_addrs", 32'({2'b00, ram_r_addr}) | 32'({2'b00, ram_w_addr}), 32'h0);
    check("reset/ram_write", 32'({ram_w_enable, ram_byte_en}), 32'h0);
    check("reset/w_val", ram_w_val, 32'h0);
    ram_clr = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw_10");
    access(1'b0, 3'b010, 32'h10, 32'h0,        0, "lw_10");
    access(1'b1, 3'b000, 32'h13, 32'h000000A5, 0, "sb_13");
    access(1'b0, 3'b000, 32'h13, 32'h0,        0, "lb_13");
    access(1'b0, 3'b100, 32'h13, 32'h0,        0, "lbu_13");
    access(1'b1, 3'b001, 32'h22, 32'h00008001, 0, "sh_22");
    access(1'b0, 3'b001, 32'h22, 32'h0,        0, "lh_22");
    access(1'b0, 3'b101, 32'h22, 32'h0,        0, "lhu_22");
    access(1'b0, 3'b010, 32'h11, 32'h0,        0, "lw_11");
    access(1'b1, 3'b001, 32'h21, 32'h0000BEEF, 0, "sh_21");
    access(1'b1, 3'b010, 32'h12, 32'h11223344, 0, "sw_12");
    access(1'b0, 3'b011, 32'h10, 32'h0,        0, "ld_f3_011");
    access(1'b0, 3'b110, 32'h10, 32'h0,        0, "ld_f3_110");
    access(1'b0, 3'b111, 32'h10, 32'h0,        0, "ld_f3_111");
    access(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, "st_f3_100");
    access(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 0, "st_f3_011");
    access(1'b0, 3'b010, 32'h10, 32'h0,        0, "lw_10_after_illegal");
    access(1'b0, 3'b010, 32'h10, 32'h0,        5, "lw_10_hold5");

    // Reset in the middle of a store: strobes drop at once and the write never lands
    access(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 0, "sw_40");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_store/in_store", 32'({ram_w_enable, ram_byte_en}), 32'h1F);
    #1 rst = 1'b1;
    #1;
    check("rst_store/byte_en", 32'(ram_byte_en), 32'h0);
    check("rst_store/w_enable", 32'(ram_w_enable), 32'h0);
    check("rst_store/handshake", 32'({req_ready, resp_valid}), 32'b10);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_store/no_resp", 32'({resp_valid, req_ready}), 32'b01);
    end
    access(1'b0, 3'b010, 32'h40, 32'h0, 0, "lw_40_after_rst");

    for (int n = 0; n < 60; n++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0)
        r_f3 = r_we ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      else
        r_f3 = 3'($urandom_range(0, 7));
      r_addr = 32'($urandom_range(0, 1023));
      access(r_we, r_f3, r_addr, $urandom, int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
